// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder
//   Pipelined carry-lookahead adder/subtractor. WIDTH bits are split into
//   NSTG = WIDTH/(BLK*BPS) slices; each pipeline stage adds one slice using BPS
//   lookahead blocks of BLK bits. The carry between slices is registered, and the
//   operands and partial sums move forward through the stage registers with the
//   slices skewed. Valid/ready handshake on both sides, full backpressure.
//
//   Ports
//     clk, rst_n            clock (rising edge), async active-low reset
//     in_valid / in_ready   operand handshake (a, b, c0, sub)
//     a, b                  WIDTH-bit operands
//     c0                    carry-in, ignored when sub=1
//     sub                   0: a+b+c0   1: a-b (a + ~b + 1)
//     out_valid / out_ready result handshake
//     sum                   WIDTH-bit result
//     cout                  carry out of the MSB (sub=1: 1 means no borrow)
//     ovf                   signed overflow
//
//   Register 0 captures the operands. Register k+1 holds the result after slice k
//   has been added. Register NSTG drives the outputs, so a transfer accepted at
//   edge N is presented after edge N+NSTG.
module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4,
  parameter int BPS   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c0,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SW   = BLK * BPS;
  localparam int NSTG = WIDTH / SW;

  logic [NSTG:0]    v;
  logic [NSTG:0]    ld;
  logic [WIDTH-1:0] ar [NSTG];
  logic [WIDTH-1:0] br [NSTG];
  logic [WIDTH-1:0] sr [NSTG+1];
  logic [NSTG:0]    cr;
  logic             cmo;

  logic [WIDTH-1:0] ns [NSTG];
  logic [NSTG-1:0]  nc;
  logic             last_cm;

  // Flattened lookahead over BLK bits. c[i+1] is the OR of every generate
  // term g[j] that propagates through p[j+1..i], plus ci when p[0..i] all propagate.
  function automatic logic [BLK:0] blk_carry(input logic [BLK-1:0] g,
                                              input logic [BLK-1:0] p,
                                              input logic           ci);
    logic [BLK:0] c;
    logic         allp;
    logic         res;
    c[0] = ci;
    for (int unsigned i = 0; i < BLK; i++) begin
      allp = 1'b1;
      res  = 1'b0;
      for (int unsigned jj = 0; jj <= i; jj++) begin
        res  = res | (g[i-jj] & allp);
        allp = allp & p[i-jj];
      end
      c[i+1] = res | (ci & allp);
    end
    return c;
  endfunction

  // The same lookahead applied one level up, over the block generate/propagate terms.
  function automatic logic [BPS:0] grp_carry(input logic [BPS-1:0] g,
                                              input logic [BPS-1:0] p,
                                              input logic           ci);
    logic [BPS:0] c;
    logic         allp;
    logic         res;
    c[0] = ci;
    for (int unsigned i = 0; i < BPS; i++) begin
      allp = 1'b1;
      res  = 1'b0;
      for (int unsigned jj = 0; jj <= i; jj++) begin
        res  = res | (g[i-jj] & allp);
        allp = allp & p[i-jj];
      end
      c[i+1] = res | (ci & allp);
    end
    return c;
  endfunction

  // Adds one SW-bit slice. The return value is packed as
  // {carry into the slice MSB, carry out, sum}.
  function automatic logic [SW+1:0] slice_add(input logic [SW-1:0] x,
                                               input logic [SW-1:0] y,
                                               input logic          ci);
    logic [SW-1:0]  g;
    logic [SW-1:0]  p;
    logic [SW-1:0]  s;
    logic [BPS-1:0] bg;
    logic [BPS-1:0] bp;
    logic [BPS:0]   bc;
    logic [BLK:0]   c;
    logic           cmsb;
    g    = x & y;
    p    = x ^ y;
    s    = '0;
    cmsb = 1'b0;
    for (int unsigned j = 0; j < BPS; j++) begin
      c     = blk_carry(g[j*BLK +: BLK], p[j*BLK +: BLK], 1'b0);
      bg[j] = c[BLK];
      bp[j] = &p[j*BLK +: BLK];
    end
    bc = grp_carry(bg, bp, ci);
    for (int unsigned j = 0; j < BPS; j++) begin
      c               = blk_carry(g[j*BLK +: BLK], p[j*BLK +: BLK], bc[j]);
      s[j*BLK +: BLK] = p[j*BLK +: BLK] ^ c[BLK-1:0];
      cmsb            = c[BLK-1];
    end
    return {cmsb, bc[BPS], s};
  endfunction

  // Slice k is added from register k into the next value of register k+1.
  always_comb begin
    logic [SW+1:0] r;
    int unsigned   lo;
    last_cm = 1'b0;
    for (int unsigned k = 0; k < NSTG; k++) begin
      lo               = k * SW;
      r                = slice_add(ar[k][lo +: SW], br[k][lo +: SW], cr[k]);
      ns[k]            = sr[k];
      ns[k][lo +: SW]  = r[SW-1:0];
      nc[k]            = r[SW];
      if (k == NSTG - 1) last_cm = r[SW+1];
    end
  end

  // Register k may load when it or any register downstream of it is empty, or
  // when the output is being taken. This is the unrolled form of
  // "empty || next register loads", so bubbles collapse.
  always_comb begin
    logic allfull;
    allfull = 1'b1;
    ld      = '0;
    for (int unsigned i = 0; i <= NSTG; i++) begin
      allfull        = allfull & v[NSTG-i];
      ld[NSTG-i]     = !allfull || out_ready;
    end
  end

  assign in_ready = ld[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v   <= '0;
      cr  <= '0;
      cmo <= 1'b0;
      for (int unsigned k = 0; k < NSTG; k++) begin
        ar[k] <= '0;
        br[k] <= '0;
      end
      for (int unsigned k = 0; k <= NSTG; k++) begin
        sr[k] <= '0;
      end
    end else begin
      if (ld[0]) begin
        v[0] <= in_valid;
        if (in_valid) begin
          ar[0] <= a;
          br[0] <= sub ? ~b : b;
          sr[0] <= '0;
          cr[0] <= sub | c0;
        end
      end
      for (int unsigned k = 0; k < NSTG; k++) begin
        if (ld[k+1]) begin
          v[k+1] <= v[k];
          if (v[k]) begin
            if (k + 1 < NSTG) begin
              ar[k+1] <= ar[k];
              br[k+1] <= br[k];
            end
            sr[k+1] <= ns[k];
            cr[k+1] <= nc[k];
            if (k == NSTG - 1) cmo <= last_cm;
          end
        end
      end
    end
  end

  assign out_valid = v[NSTG];
  assign sum       = sr[NSTG];
  assign cout      = cr[NSTG];
  assign ovf       = cr[NSTG] ^ cmo;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder
//   Directed and random stimulus for pipelined_cla_adder (WIDTH=16, BLK=4,
//   BPS=1). Expected results come from plain 17-bit arithmetic and a FIFO
//   scoreboard of accepted transactions.
module tb_pipelined_cla_adder;

  localparam int W    = 16;
  localparam int NSTG = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c0;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  pipelined_cla_adder #(.WIDTH(W), .BLK(4), .BPS(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .c0       (c0),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int          npush    = 0;
  int          nrecv    = 0;
  int          nflush   = 0;
  logic [17:0] q[$];
  bit          prev_stall = 1'b0;
  logic [17:0] prev_out;

  // {ovf, cout, sum} from plain arithmetic; overflow when both addend signs
  // agree and the result sign differs.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci, input logic s);
    logic [16:0] r;
    logic [15:0] yy;
    yy = s ? ~y : y;
    r  = {1'b0, x} + {1'b0, yy} + (s ? 17'd1 : {16'd0, ci});
    return {(x[15] == yy[15]) && (r[15] != x[15]), r};
  endfunction

  // One clock: sample just after the falling edge, check output against the
  // scoreboard, record any input transfer, then advance to the next falling edge.
  task automatic tick(output bit acc);
    logic [17:0] obs;
    logic [17:0] exp;
    #1;
    obs = {ovf, cout, sum};
    if (prev_stall) begin
      checks++;
      assert (out_valid === 1'b1 && obs === prev_out)
        else begin
          failures++;
          $error("FAIL hold obs=%h valid=%b exp=%h valid=1", obs, out_valid, prev_out);
        end
    end
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      checks++;
      assert (q.size() > 0)
        else begin
          failures++;
          $error("FAIL spurious obs=%h exp=no_result", obs);
        end
      if (q.size() > 0) begin
        exp = q.pop_front();
        nrecv++;
        checks++;
        assert (obs === exp)
          else begin
            failures++;
            $error("FAIL result obs=%h exp=%h", obs, exp);
          end
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_out   = obs;
    if (acc) begin
      q.push_back(model(a, b, c0, sub));
      npush++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Single transaction with constant expectations and exact latency check.
  // Sample n after acceptance sees the state after edge N+n-1, so the result
  // must first appear at sample NSTG+1.
  task automatic run_one(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                         input logic ts, input logic [15:0] es, input logic ec,
                         input logic eo, input string tag);
    bit acc;
    bit seen;
    int n;
    a = ta; b = tb_; c0 = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 20) begin
      tick(acc);
      n++;
    end
    in_valid = 1'b0;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 20) begin
      n++;
      #1;
      if (out_valid) seen = 1'b1;
      else tick(acc);
    end
    checks++;
    assert (seen && n == NSTG + 1)
      else begin
        failures++;
        $error("FAIL %s_latency obs=%0d seen=%b exp=%0d", tag, n, seen, NSTG + 1);
      end
    checks++;
    assert ({ovf, cout, sum} === {eo, ec, es})
      else begin
        failures++;
        $error("FAIL %s obs=%b/%b/%h exp=%b/%b/%h", tag, ovf, cout, sum, eo, ec, es);
      end
    tick(acc);
  endtask

  initial begin : main
    bit          acc;
    bit          pend;
    bit          saw_block;
    bit          stale;
    int          idx;
    int          t;
    int          cyc;
    int          nsent;
    int          r0;
    logic [15:0] va [8];
    logic [15:0] vb [8];

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c0 = 1'b0; sub = 1'b0;

    // 1: reset state
    @(negedge clk);
    #1;
    checks++;
    assert ({out_valid, ovf, cout, sum} === 19'd0)
      else begin
        failures++;
        $error("FAIL reset obs=%b/%b/%b/%h exp=0/0/0/0000", out_valid, ovf, cout, sum);
      end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    assert (in_ready === 1'b1)
      else begin
        failures++;
        $error("FAIL reset_in_ready obs=%b exp=1", in_ready);
      end
    @(negedge clk);

    // 2-4: directed vectors
    run_one(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "wrap");
    run_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "pos_ovf");
    run_one(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, "carry_in");
    run_one(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");
    run_one(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
    run_one(16'h1234, 16'h0000, 1'b1, 1'b1, 16'h1234, 1'b1, 1'b0, "sub_zero");

    // 5: 8 back-to-back with a 3-cycle output stall
    for (int i = 0; i < 8; i++) begin
      va[i] = 16'($urandom);
      vb[i] = 16'($urandom);
    end
    idx = 0; t = 0; saw_block = 1'b0; r0 = nrecv;
    while ((idx < 8 || q.size() > 0) && t < 100) begin
      in_valid = (idx < 8);
      if (idx < 8) begin
        a = va[idx]; b = vb[idx]; sub = idx[0]; c0 = idx[1];
      end
      out_ready = !(t >= 6 && t < 9);
      #1;
      if (in_valid && !in_ready) saw_block = 1'b1;
      tick(acc);
      if (acc) idx++;
      t++;
    end
    in_valid = 1'b0;
    checks++;
    assert (saw_block)
      else begin
        failures++;
        $error("FAIL stall_in_ready obs=never_low exp=low");
      end
    checks++;
    assert (nrecv - r0 == 8 && q.size() == 0)
      else begin
        failures++;
        $error("FAIL stream_count obs=%0d pending=%0d exp=8 pending=0", nrecv - r0, q.size());
      end

    // 6: reset with 3 transactions in flight
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 16'(16'h1111 * (i + 1)); b = 16'h0F0F; c0 = 1'b0; sub = 1'b0;
      tick(acc);
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    assert (out_valid === 1'b0 && sum === 16'h0000)
      else begin
        failures++;
        $error("FAIL mid_reset obs=%b/%h exp=0/0000", out_valid, sum);
      end
    nflush += q.size();
    q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (out_valid) stale = 1'b1;
      tick(acc);
    end
    checks++;
    assert (!stale)
      else begin
        failures++;
        $error("FAIL stale_after_reset obs=valid exp=none");
      end

    // random traffic with random handshakes
    nsent = 0; cyc = 0; pend = 1'b0;
    while (nsent < 10000 && cyc < 60000) begin
      if (!pend) begin
        in_valid = ($urandom_range(0, 3) != 0);
        a   = 16'($urandom);
        b   = 16'($urandom);
        c0  = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
        pend = in_valid;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick(acc);
      cyc++;
      if (acc) begin
        nsent++;
        pend = 1'b0;
      end
    end
    in_valid = 1'b0;
    checks++;
    assert (nsent == 10000)
      else begin
        failures++;
        $error("FAIL random_budget obs=%0d exp=10000", nsent);
      end
    out_ready = 1'b1;
    cyc = 0;
    while (q.size() > 0 && cyc < 100) begin
      tick(acc);
      cyc++;
    end
    checks++;
    assert (q.size() == 0 && nrecv == npush - nflush)
      else begin
        failures++;
        $error("FAIL drain obs=recv%0d pending%0d exp=recv%0d pending0",
               nrecv, q.size(), npush - nflush);
      end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
